bp_cache: RTL and testbench

BP_CACHE -- requirements
Module: bp_cache

---
 rtl/bp_cache.sv | 49 ++++
 tb/tb_bp_cache.sv | 138 +++++++++++++
 2 files changed

// File: rtl/bp_cache.sv
// bp_cache: direct-mapped, dual-read single-write lookup cache with combinational hit/data.
module bp_cache #(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32,
  parameter int LINES  = 128
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [AWIDTH-1:0] ra0,
  input  logic [AWIDTH-1:0] ra1,
  input  logic [AWIDTH-1:0] wa,
  input  logic [DWIDTH-1:0] din,
  input  logic              we,
  output logic [DWIDTH-1:0] dout0,
  output logic [DWIDTH-1:0] dout1,
  output logic              hit0,
  output logic              hit1
);
  localparam int IB = $clog2(LINES);
  localparam int TW = AWIDTH - IB - 2;
  logic [LINES-1:0]  valid;
  logic [TW-1:0]     tags [LINES];
  logic [DWIDTH-1:0] data [LINES];
  logic [IB-1:0]     i0, i1, iw;
  logic [TW-1:0]     t0, t1, tw;
  logic              unused_bits;
  assign unused_bits = ^{ra0[1:0], ra1[1:0], wa[1:0]};
  assign i0 = ra0[IB+1:2];
  assign i1 = ra1[IB+1:2];
  assign iw = wa[IB+1:2];
  assign t0 = ra0[AWIDTH-1:IB+2];
  assign t1 = ra1[AWIDTH-1:IB+2];
  assign tw = wa[AWIDTH-1:IB+2];
  // valid gates everything, so tag/data storage can stay unreset
  always_ff @(posedge clk or posedge reset)
    if (reset) valid <= '0;
    else if (we) valid[iw] <= 1'b1;
  always_ff @(posedge clk)
    if (we && !reset) begin
      tags[iw] <= tw;
      data[iw] <= din;
    end
  always_comb begin
    hit0  = valid[i0] && (tags[i0] == t0);
    hit1  = valid[i1] && (tags[i1] == t1);
    dout0 = hit0 ? data[i0] : '0;
    dout1 = hit1 ? data[i1] : '0;
  end
endmodule

// File: tb/tb_bp_cache.sv
// tb_bp_cache: directed and randomized checks of bp_cache against a word-address reference model.
module tb_bp_cache;
  localparam int L = 128;
  logic        clk = 0;
  logic        reset = 1;
  logic [31:0] ra0 = 0, ra1 = 0, wa = 0, din = 0;
  logic        we = 0;
  logic [31:0] dout0, dout1;
  logic        hit0, hit1;
  int checks = 0;
  int failures = 0;
  bit          mval [L];
  int unsigned mword [L];
  logic [31:0] mdata [L];

  bp_cache #(.AWIDTH(32), .DWIDTH(32), .LINES(L)) dut (
    .clk(clk), .reset(reset), .ra0(ra0), .ra1(ra1), .wa(wa), .din(din), .we(we),
    .dout0(dout0), .dout1(dout1), .hit0(hit0), .hit1(hit1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit m_hit(input logic [31:0] a);
    int unsigned w = a >> 2;
    return mval[w % L] && mword[w % L] == w;
  endfunction

  function automatic logic [31:0] m_data(input logic [31:0] a);
    return m_hit(a) ? mdata[(a >> 2) % L] : 32'h0;
  endfunction

  task automatic m_clear();
    foreach (mval[i]) mval[i] = 0;
  endtask

  task automatic check_ports(input string ph);
    chk({ph, "_hit0"}, {31'b0, hit0}, {31'b0, m_hit(ra0)});
    chk({ph, "_dout0"}, dout0, m_data(ra0));
    chk({ph, "_hit1"}, {31'b0, hit1}, {31'b0, m_hit(ra1)});
    chk({ph, "_dout1"}, dout1, m_data(ra1));
  endtask

  task automatic cyc(input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [31:0] r0, input logic [31:0] r1);
    int unsigned wd;
    @(negedge clk);
    we = w; wa = a; din = d; ra0 = r0; ra1 = r1;
    #1 check_ports("pre");
    @(posedge clk);
    if (w && !reset) begin
      wd = a >> 2;
      mval[wd % L] = 1; mword[wd % L] = wd; mdata[wd % L] = d;
    end
    #1 check_ports("post");
    we = 0;
  endtask

  task automatic mid_reset();
    @(negedge clk);
    #2 reset = 1;
    m_clear();
    #1;
    chk("arst_hit0", {31'b0, hit0}, 32'h0);
    chk("arst_hit1", {31'b0, hit1}, 32'h0);
    chk("arst_dout0", dout0, 32'h0);
    we = 1; wa = ra0; din = 32'hBAD0BAD0;
    @(posedge clk);
    #1 chk("rst_wr_ignored", {31'b0, hit0}, 32'h0);
    @(negedge clk);
    we = 0; reset = 0;
  endtask

  initial begin
    logic [31:0] a, r0, r1;
    m_clear();
    repeat (10) @(posedge clk);
    @(negedge clk) reset = 0;
    cyc(0, 0, 0, 32'h0, 32'h0);
    chk("init_hit0", {31'b0, hit0}, 32'h0);
    chk("init_dout0", dout0, 32'h0);
    chk("init_hit1", {31'b0, hit1}, 32'h0);
    chk("init_dout1", dout1, 32'h0);
    cyc(1, 32'h4, 32'hDEADBEEF, 32'h0, 32'h0);
    cyc(0, 0, 0, 32'h4, 32'h4);
    chk("wr_hit0", {31'b0, hit0}, 32'h1);
    chk("wr_dout0", dout0, 32'hDEADBEEF);
    chk("wr_hit1", {31'b0, hit1}, 32'h1);
    chk("wr_dout1", dout1, 32'hDEADBEEF);
    cyc(0, 0, 0, 32'h7, 32'h4);
    chk("lowbit_hit0", {31'b0, hit0}, 32'h1);
    chk("lowbit_dout0", dout0, 32'hDEADBEEF);
    cyc(1, 32'h4, 32'h11111111, 32'h4, 32'h204);
    cyc(1, 32'h204, 32'h22222222, 32'h204, 32'h4);
    chk("alias_hit0", {31'b0, hit0}, 32'h1);
    chk("alias_dout0", dout0, 32'h22222222);
    chk("alias_miss1", {31'b0, hit1}, 32'h0);
    chk("alias_dout1", dout1, 32'h0);
    @(negedge clk);
    we = 1; wa = 32'h10; din = 32'hA5A5A5A5; ra0 = 32'h10; ra1 = 32'h10;
    #1 chk("same_pre_hit0", {31'b0, hit0}, 32'h0);
    @(posedge clk);
    mval[4] = 1; mword[4] = 4; mdata[4] = 32'hA5A5A5A5;
    #1 chk("same_post_hit0", {31'b0, hit0}, 32'h1);
    chk("same_post_dout0", dout0, 32'hA5A5A5A5);
    we = 0;
    for (int i = 0; i < 6; i++) cyc(1, 32'h100 + 32'(i * 4), 32'hC0DE0000 + 32'(i), 32'h100, 32'h10);
    mid_reset();
    cyc(0, 0, 0, 32'h100, 32'h204);
    chk("after_rst_miss0", {31'b0, hit0}, 32'h0);
    chk("after_rst_miss1", {31'b0, hit1}, 32'h0);
    for (int i = 0; i < 600; i++) begin
      a  = ($urandom_range(0, 511) << 2) | $urandom_range(0, 3);
      r0 = ($urandom_range(0, 511) << 2) | $urandom_range(0, 3);
      r1 = ($urandom_range(0, 3) == 0) ? r0 : (($urandom_range(0, 511) << 2) | $urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) r0 = a;
      cyc($urandom_range(0, 2) != 0, a, $urandom, r0, r1);
      if (i % 150 == 149) mid_reset();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    failures++;
    $display("FAIL timeout observed=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end
endmodule
